// File: rtl/alu_seq_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_exec                                                     |
// | Function : Execute unit with valid/ready on both sides. Logical, arithmetic |
// |            and compare ops finish in one edge. Shifts step one bit per edge |
// |            unless ALU_SEQ_BARREL_SHIFT_EN selects a one-edge barrel shifter.|
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_seq_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam logic [3:0] c_OR   = 4'b0000;
  localparam logic [3:0] c_SLL  = 4'b0001;
  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_SRL  = 4'b0011;
  localparam logic [3:0] c_XOR  = 4'b0100;
  localparam logic [3:0] c_SRA  = 4'b0101;
  localparam logic [3:0] c_SUB  = 4'b0110;
  localparam logic [3:0] c_SLT  = 4'b0111;
  localparam logic [3:0] c_SLTU = 4'b1000;
  localparam logic [3:0] c_AND  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_iter_start;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  assign w_shamt = op_b[SHW-1:0];

  // Single-edge datapath; in the iterative build a shift here only covers k=0.
  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      c_ADD:  w_alu = op_a + op_b;
      c_SUB:  w_alu = op_a - op_b;
      c_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      c_XOR:  w_alu = op_a ^ op_b;
      c_OR:   w_alu = op_a | op_b;
      c_AND:  w_alu = op_a & op_b;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
      c_SLL:  w_alu = op_a << w_shamt;
      c_SRL:  w_alu = op_a >> w_shamt;
      c_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
`else
      c_SLL, c_SRL, c_SRA: w_alu = op_a;
`endif
      default: w_alu = '0;
    endcase
  end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] r_work;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] w_step;
  logic            w_is_shift;
  logic            w_shift_done;

  assign w_is_shift   = (alu_ctrl == c_SLL) || (alu_ctrl == c_SRL) || (alu_ctrl == c_SRA);
  assign w_iter_start = w_accept && w_is_shift && (w_shamt != '0);
  assign w_shift_done = (r_state == S_SHIFT) && (r_cnt == SHW'(1)) && !flush;

  always_comb begin
    w_step = r_work;
    case (r_ctrl)
      c_SLL:   w_step = {r_work[XLEN-2:0], 1'b0};
      c_SRL:   w_step = {1'b0, r_work[XLEN-1:1]};
      default: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_work <= '0;
      r_ctrl <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_iter_start) begin
      r_work <= op_a;
      r_ctrl <= alu_ctrl;
      r_cnt  <= w_shamt;
    end else if (r_state == S_SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end
`else
  assign w_iter_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_DONE;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
          if (w_is_shift && (w_shamt != '0)) w_next = S_SHIFT;
`endif
        end
      end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
      S_SHIFT: if (r_cnt == SHW'(1)) w_next = S_DONE;
`endif
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Flush outranks everything but reset, including a same-edge accept.
    if (flush) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
    end
  end

  // Result/zero only move on completion, so flush leaves the last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && !w_iter_start) begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
    end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
    else if (w_shift_done) begin
      r_result <= w_step;
      r_zero   <= (w_step == '0);
    end
`endif
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;
  assign zero      = r_zero;

endmodule
`default_nettype wire
